// File: rtl/rv_top_pkg.sv
// Shared definitions for the CPU top level: loader FSM encoding and memory word stride.
package rv_top_pkg;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } ld_state_e;

  localparam int unsigned WordStride = 4;

endpackage

// File: rtl/ld_addr_gen.sv
// Burst address generator: word-aligned address register, remaining-word counter,
// data-memory range check and last-word detect.
module ld_addr_gen
  import rv_top_pkg::*;
#(
  parameter int unsigned      ADDR_W      = 32,
  parameter int unsigned      DEPTH_WORDS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADR   = '0,
  parameter int unsigned      CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [CNT_W-1:0]  ld_count,
  output logic [ADDR_W-1:0] adr,
  output logic [CNT_W-1:0]  rem,
  output logic              in_range,
  output logic              last_word
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(WordStride - 1);
  localparam logic [ADDR_W-1:0] StrideAdr = ADDR_W'(WordStride);
  localparam logic [ADDR_W:0]   SpanBytes = (ADDR_W + 1)'(WordStride * DEPTH_WORDS);

  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W:0]   offset;

  always_comb begin
    adr_d = adr_q;
    rem_d = rem_q;
    if (load) begin
      adr_d = ld_adr & AlignMask;
      rem_d = ld_count;
    end else if (advance) begin
      adr_d = adr_q + StrideAdr;
      if (rem_q != '0) begin
        rem_d = rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr_q <= '0;
      rem_q <= '0;
    end else begin
      adr_q <= adr_d;
      rem_q <= rem_d;
    end
  end

  // One extra bit keeps addresses below BASE_ADR from wrapping into the window.
  assign offset    = {1'b0, adr_q} - {1'b0, BASE_ADR};
  assign in_range  = (offset < SpanBytes);
  assign last_word = (rem_q == CNT_W'(1));
  assign adr       = adr_q;
  assign rem       = rem_q;

endmodule

// File: rtl/dmem_loader_arbiter.sv
// External burst loader with data-memory port arbitration: the host owns the port and the
// CPU is held in reset while loading; the CPU owns the port in RUN.
module dmem_loader_arbiter
  import rv_top_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADR    = '0,
  parameter int unsigned       CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [CNT_W-1:0]  ld_count,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              cpu_reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata
);

  ld_state_e         state_q, state_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              start_take;
  logic              count_zero;
  logic [ADDR_W-1:0] adr;
  logic [CNT_W-1:0]  rem;
  logic              in_range;
  logic              last_word;

  ld_addr_gen #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .BASE_ADR    (BASE_ADR),
    .CNT_W       (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (start_take),
    .advance   (accept),
    .ld_adr    (ld_adr),
    .ld_count  (ld_count),
    .adr       (adr),
    .rem       (rem),
    .in_range  (in_range),
    .last_word (last_word)
  );

  assign accept     = ld_valid && (state_q == StLoad);
  // A start during LOAD is dropped so a running burst cannot be corrupted.
  assign start_take = ld_start && (state_q != StLoad);
  assign count_zero = (ld_count == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold: begin
        if (start_take) begin
          state_d = count_zero ? StRun : StLoad;
        end
      end
      StLoad: begin
        if (accept && last_word) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (start_take && !count_zero) begin
          state_d = StLoad;
        end
      end
      default: state_d = StHold;
    endcase
  end

  // Done marks entry into RUN only; a RUN->RUN reload with count 0 stays silent.
  always_comb begin
    done_d = (state_q != StRun) && (state_d == StRun);
    err_d  = err_q;
    if (start_take) begin
      err_d = 1'b0;
    end else if (accept && !in_range) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHold;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cpu_reset = (state_q != StRun);
  assign ld_ready  = (state_q == StLoad);
  assign ld_done   = done_q;
  assign ld_err    = err_q;

  always_comb begin
    mem_we    = accept && in_range;
    mem_adr   = adr;
    mem_wdata = ld_data;
    if (state_q == StRun) begin
      mem_we    = cpu_we;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
    end
  end

  logic unused_rem;
  assign unused_rem = ^rem;

endmodule

// File: tb/tb_dmem_loader_arbiter.sv
// Self-checking bench for dmem_loader_arbiter: directed test-plan scenarios plus random traffic,
// all compared every cycle against a behavioural loader/arbiter model.
module tb_dmem_loader_arbiter;

  localparam int unsigned DataW  = 32;
  localparam int unsigned AdrW   = 32;
  localparam int unsigned Depth  = 64;
  localparam int unsigned CntW   = $clog2(Depth) + 1;
  localparam longint      Base   = 0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ld_start = 1'b0;
  logic [AdrW-1:0]   ld_adr = '0;
  logic [CntW-1:0]   ld_count = '0;
  logic              ld_valid = 1'b0;
  logic [DataW-1:0]  ld_data = '0;
  logic              ld_ready, ld_done, ld_err, cpu_reset;
  logic              cpu_we = 1'b0;
  logic [AdrW-1:0]   cpu_adr = '0;
  logic [DataW-1:0]  cpu_wdata = '0;
  logic              mem_we;
  logic [AdrW-1:0]   mem_adr;
  logic [DataW-1:0]  mem_wdata;

  dmem_loader_arbiter #(
    .DATA_W      (DataW),
    .ADDR_W      (AdrW),
    .DEPTH_WORDS (Depth),
    .BASE_ADR    ('0),
    .CNT_W       (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_adr    (ld_adr),
    .ld_count  (ld_count),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .cpu_reset (cpu_reset),
    .cpu_we    (cpu_we),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the port, where the next host word goes, how many remain.
  bit          m_loading = 0;
  bit          m_running = 0;
  logic [31:0] m_adr = '0;
  int          m_left = 0;
  bit          m_err = 0;
  bit          m_done = 0;

  function automatic bit in_window(input logic [31:0] a);
    return (longint'(a) >= Base) && (longint'(a) < Base + 4 * longint'(Depth));
  endfunction

  always @(negedge clk) begin
    bit acc;
    bit nxt_done;
    if (reset) begin
      m_loading = 0; m_running = 0; m_adr = '0; m_left = 0; m_err = 0; m_done = 0;
      check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      check("rst_ld_ready", 64'(ld_ready), 64'd0);
      check("rst_ld_done", 64'(ld_done), 64'd0);
      check("rst_ld_err", 64'(ld_err), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_adr", 64'(mem_adr), 64'd0);
    end else begin
      acc = m_loading && ld_valid;
      check("cpu_reset", 64'(cpu_reset), 64'(!m_running));
      check("ld_ready", 64'(ld_ready), 64'(m_loading));
      check("ld_done", 64'(ld_done), 64'(m_done));
      check("ld_err", 64'(ld_err), 64'(m_err));
      if (m_running) begin
        check("mem_we", 64'(mem_we), 64'(cpu_we));
        check("mem_adr", 64'(mem_adr), 64'(cpu_adr));
        check("mem_wdata", 64'(mem_wdata), 64'(cpu_wdata));
      end else begin
        check("mem_we", 64'(mem_we), 64'(acc && in_window(m_adr)));
        check("mem_adr", 64'(mem_adr), 64'(m_adr));
        check("mem_wdata", 64'(mem_wdata), 64'(ld_data));
      end
      nxt_done = 0;
      if (m_loading) begin
        if (acc) begin
          if (!in_window(m_adr)) m_err = 1;
          m_adr = m_adr + 32'd4;
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_loading = 0;
            m_running = 1;
            nxt_done = 1;
          end
        end
      end else if (ld_start) begin
        m_adr = {ld_adr[31:2], 2'b00};
        m_left = int'(ld_count);
        m_err = 0;
        if (ld_count != 0) begin
          m_loading = 1;
          m_running = 0;
        end else begin
          if (!m_running) nxt_done = 1;
          m_running = 1;
        end
      end
      m_done = nxt_done;
    end
  end

  // Write log for the hand-computed scenario checks.
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];

  always @(negedge clk) begin
    if (!reset && mem_we) begin
      log_adr.push_back(mem_adr);
      log_dat.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
  endtask

  task automatic start(input logic [31:0] a, input int n);
    ld_start = 1; ld_adr = a; ld_count = CntW'(n);
    tick();
    ld_start = 0;
  endtask

  task automatic push_word(input logic [31:0] d, input int stall);
    for (int i = 0; i < stall; i++) begin
      ld_valid = 0;
      tick();
    end
    ld_valid = 1; ld_data = d;
    tick();
    ld_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  initial begin
    logic [31:0] exp_a[3];
    logic [31:0] exp_d[3];

    do_reset();

    // Burst load of three words at 0x10
    clear_log();
    start(32'h10, 3);
    push_word(32'hA0A0_0001, 0);
    push_word(32'hB0B0_0002, 0);
    push_word(32'hC0C0_0003, 0);
    check("burst_done", 64'(ld_done), 64'd1);
    check("burst_cpu_reset", 64'(cpu_reset), 64'd0);
    exp_a = '{32'h10, 32'h14, 32'h18};
    exp_d = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    check("burst_nwrites", 64'(log_adr.size()), 64'd3);
    for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
      check("burst_wadr", 64'(log_adr[i]), 64'(exp_a[i]));
      check("burst_wdat", 64'(log_dat[i]), 64'(exp_d[i]));
    end
    tick();
    check("burst_done_once", 64'(ld_done), 64'd0);

    // Same burst with a stalling host
    clear_log();
    start(32'h10, 3);
    push_word(32'hA0A0_0001, 2);
    push_word(32'hB0B0_0002, 2);
    push_word(32'hC0C0_0003, 2);
    check("stall_done", 64'(ld_done), 64'd1);
    check("stall_nwrites", 64'(log_adr.size()), 64'd3);
    for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
      check("stall_wadr", 64'(log_adr[i]), 64'(exp_a[i]));
    end

    // Burst running off the end of memory
    clear_log();
    start(32'hF8, 4);
    for (int i = 0; i < 4; i++) begin
      check("oor_ready", 64'(ld_ready), 64'd1);
      push_word(32'h5000 + 32'(i), 0);
    end
    check("oor_err", 64'(ld_err), 64'd1);
    check("oor_run", 64'(cpu_reset), 64'd0);
    check("oor_nwrites", 64'(log_adr.size()), 64'd2);
    if (log_adr.size() == 2) begin
      check("oor_wadr0", 64'(log_adr[0]), 64'h0F8);
      check("oor_wadr1", 64'(log_adr[1]), 64'h0FC);
    end

    // Reload from RUN while the CPU stores
    clear_log();
    cpu_we = 1; cpu_adr = 32'h20; cpu_wdata = 32'hDEAD_BEEF;
    ld_start = 1; ld_adr = 32'h0; ld_count = CntW'(1);
    tick();
    ld_start = 0; cpu_we = 0;
    check("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    check("reload_err_clr", 64'(ld_err), 64'd0);
    push_word(32'h1234_5678, 0);
    check("reload_nwrites", 64'(log_adr.size()), 64'd2);
    if (log_adr.size() == 2) begin
      check("reload_cpu_adr", 64'(log_adr[0]), 64'h20);
      check("reload_cpu_dat", 64'(log_dat[0]), 64'hDEAD_BEEF);
      check("reload_host_adr", 64'(log_adr[1]), 64'h0);
      check("reload_host_dat", 64'(log_dat[1]), 64'h1234_5678);
    end

    // Count zero straight from HOLD
    do_reset();
    clear_log();
    start(32'h30, 0);
    check("zero_done", 64'(ld_done), 64'd1);
    check("zero_cpu_reset", 64'(cpu_reset), 64'd0);
    tick();
    check("zero_nwrites", 64'(log_adr.size()), 64'd0);
    start(32'h30, 0);
    check("zero_rerun_done", 64'(ld_done), 64'd0);

    // Asynchronous reset part-way through a burst
    clear_log();
    start(32'h40, 3);
    push_word(32'h0000_0111, 0);
    ld_valid = 1; ld_data = 32'h0000_0222;
    reset = 1;
    #1;
    check("arst_ready", 64'(ld_ready), 64'd0);
    check("arst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("arst_mem_we", 64'(mem_we), 64'd0);
    tick();
    tick();
    reset = 0; ld_valid = 0;
    tick();
    check("arst_nwrites", 64'(log_adr.size()), 64'd1);
    check("arst_err", 64'(ld_err), 64'd0);
    check("arst_hold", 64'(cpu_reset), 64'd1);

    // Random traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [31:0] sel;
      sel = $urandom_range(0, 7);
      ld_start = ($urandom_range(0, 9) == 0);
      case (sel)
        0, 1:    ld_adr = 32'($urandom_range(0, 255));
        2:       ld_adr = 32'hF0 + 32'($urandom_range(0, 31));
        3:       ld_adr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: ld_adr = $urandom;
      endcase
      ld_count  = CntW'($urandom_range(0, 6));
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_data   = $urandom;
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_adr   = $urandom;
      cpu_wdata = $urandom;
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    ld_start = 0;
    ld_valid = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_loader_arbiter.md
# dmem_loader_arbiter

Parametrised external-load controller and data-memory port arbiter for the RISC-V CPU top level. It accepts a burst of words from a host over a valid/ready stream and writes them to data memory at auto-incrementing word addresses. While loading, it holds the CPU in reset. When the burst completes, it releases the CPU and hands the memory port back to it. A new load may be started at any time, which re-halts the CPU.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, byte address width
- DEPTH_WORDS, 64, data-memory depth in words
- BASE_ADR, 0, byte address of the first memory word
- CNT_W, $clog2(DEPTH_WORDS)+1, burst-count width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ld_start  in  1  single-cycle request to begin a burst
- ld_adr  in  ADDR_W  burst start byte address; bits [1:0] ignored
- ld_count  in  CNT_W  number of words in the burst
- ld_valid  in  1  host word valid
- ld_data  in  DATA_W  host word
- ld_ready  out  1  block accepts a word this cycle
- ld_done  out  1  one-cycle pulse when the CPU is released
- ld_err  out  1  sticky flag: an out-of-range write was dropped
- cpu_reset  out  1  reset to the CPU core
- cpu_we  in  1  CPU store enable
- cpu_adr  in  ADDR_W  CPU data address
- cpu_wdata  in  DATA_W  CPU store data
- mem_we  out  1  data-memory write enable
- mem_adr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data

## Operation
States:
- HOLD (reset state)
  - cpu_reset=1, ld_ready=0.
  - ld_start with ld_count≠0 → LOAD.
  - ld_start with ld_count=0 → RUN.
- LOAD
  - cpu_reset=1, ld_ready=1.
  - Accept when ld_valid&ld_ready. On accept: write ld_data at adr_q, adr_q+=4, rem-=1.
  - Accepting the word with rem=1 → RUN.
  - ld_start is ignored in LOAD.
- RUN
  - cpu_reset=0, ld_ready=0. Memory port follows cpu_*.
  - ld_start with ld_count≠0 → LOAD; with ld_count=0 → stay in RUN.
  - Either way, adr_q and rem are reloaded.

Muxing:
- Outside RUN: mem_adr=adr_q, mem_wdata=ld_data, mem_we=accept & in_range.
- In RUN: mem_* = cpu_*.

Range and width rules:
- in_range means BASE_ADR ≤ adr_q < BASE_ADR+4·DEPTH_WORDS.
- An out-of-range word is still consumed and counted, but not written, and sets ld_err.
- ld_err clears only on reset or on an accepted ld_start.
- adr_q is loaded as {ld_adr[ADDR_W-1:2],2'b00} and wraps modulo 2^ADDR_W.
- rem is CNT_W bits and never underflows.

## Timing
- Reset values: state=HOLD, cpu_reset=1, ld_ready=0, ld_done=0, ld_err=0, mem_we=0, adr_q=0, rem=0.
- cpu_reset, ld_ready and ld_done decode from registered state. ld_start therefore takes effect one cycle after it is sampled.
- In the RUN cycle where ld_start is sampled, the CPU still owns the port and its store completes.
- mem_we/mem_adr/mem_wdata are combinational in the accept cycle. The write lands at the same clk edge as the accept, with zero added latency.
- Throughput: one word per cycle while ld_valid is held.
- Host stalls are allowed: with ld_valid=0 there is no state change.
- ld_done pulses in the first cycle of RUN after a LOAD, or after HOLD→RUN on count 0. It does not pulse on a RUN→RUN reload with count 0.
- Burst of N words: last accept in cycle t, RUN and ld_done in cycle t+1.
- Asynchronous reset mid-LOAD aborts the burst. Words already written remain in memory and the block returns to HOLD.

## Structure
- Shared package rv_top_pkg holds:
  - state encoding HOLD=2'd0, LOAD=2'd1, RUN=2'd2
  - word stride constant 4
- One sub-module is natural: ld_addr_gen. It owns adr_q, rem, the in_range compare, and the last-word detect.
- The FSM, ld_err and the mux stay in dmem_loader_arbiter.
- The top level instantiates this block between riscv_cpu and data_mem.

## Test plan
- Burst load: reset, ld_start adr=0x10 count=3, data A,B,C back-to-back.
  - Expect writes at 0x10, 0x14, 0x18.
  - Expect ld_done one cycle after C, then cpu_reset=0.
- Stalled host: same burst with ld_valid low for 2 cycles between words.
  - Expect identical writes and no extra mem_we pulses.
- Out of range: DEPTH_WORDS=64, ld_start adr=0xF8 count=4.
  - Expect writes at 0xF8 and 0xFC only, ld_err=1, 4 words consumed, RUN entered.
- Re-load during RUN: CPU store to 0x20 in the same cycle as ld_start adr=0 count=1.
  - Expect the CPU store written.
  - Expect cpu_reset=1 the next cycle, then the host write at 0x0.
- Count zero from HOLD: ld_start count=0 → RUN next cycle, ld_done pulse, no memory writes.
- Async reset mid-burst: reset after word 1 of 3.
  - Expect immediate HOLD, ld_ready=0, no further writes, ld_err=0.
